// File: rtl/srt2_div8_if.sv
// srt2_div8_if: start/operand request and busy/done/result response bundle for srt2_div8.
interface srt2_div8_if;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] quot;
   logic [7:0] rem;
   modport master (output start, dividend, divisor, input busy, done, err, quot, rem);
   modport slave (input start, dividend, divisor, output busy, done, err, quot, rem);
endinterface

// File: rtl/srt2_div8.sv
// srt2_div8: radix-2 SRT divider, 8-bit normalized fractions, carry-save remainder, on-the-fly quotient.
// Define SRT_DIV_REM_EN to build the rem output and its +D correction adder; otherwise rem is 0.
module srt2_div8 (
   input logic        clk,
   input logic        reset,
   srt2_div8_if.slave bus
);
   typedef enum logic [2:0] {IDLE, RUN, FIX, ERR, DONE} state_t;
   state_t      state_q, state_d;
   logic [10:0] ws_q, ws_d, wc_q, wc_d;
   logic [7:0]  q_q, q_d, qm_q, qm_d, d_q, d_d, quot_q, quot_d, rem_q, rem_d;
   logic [2:0]  count_q, count_d;
   logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [10:0] sum_n2, carry_n2, mdivi, sum, carry;
   logic [4:0]  y;
   logic [7:0]  rem_fix;
   logic        qpos, qneg, w_neg, accept, bad;
   // The +D carry-in is the current digit's; y only sees bits [10:6], so bit 0 never loops back into selection.
   assign sum_n2   = {ws_q[9:0], 1'b0};
   assign carry_n2 = {wc_q[9:0], qpos};
   assign y        = sum_n2[10:6] + carry_n2[10:6];
   assign qpos     = ~y[4];
   assign qneg     = y[4] & ~&y[3:1];
   assign mdivi    = qpos ? ~{3'b000, d_q} : qneg ? {3'b000, d_q} : 11'd0;
   assign w_neg    = 11'(ws_q + wc_q) >= 11'h400;
`ifdef SRT_DIV_REM_EN
   assign rem_fix  = ws_q[7:0] + wc_q[7:0] + (w_neg ? d_q : 8'h00);
`else
   assign rem_fix  = 8'h00;
`endif
   csa11 u_csa (.mdivi(mdivi), .SumN2(sum_n2), .CarryN2(carry_n2), .Sum(sum), .Carry(carry));
   always_comb begin
      accept  = (state_q == IDLE || state_q == DONE) && bus.start;
      bad     = ~bus.divisor[7] || bus.dividend >= bus.divisor;
      state_d = state_q;
      ws_d    = ws_q;
      wc_d    = wc_q;
      q_d     = q_q;
      qm_d    = qm_q;
      d_d     = d_q;
      count_d = count_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      if (accept && bad) begin
         state_d = ERR;
         err_d   = 1'b0;
      end else if (accept) begin
         state_d = RUN;
         busy_d  = 1'b1;
         err_d   = 1'b0;
         ws_d    = {3'b000, bus.dividend};
         wc_d    = '0;
         q_d     = '0;
         qm_d    = '0;
         count_d = '0;
         d_d     = bus.divisor;
      end else if (state_q == RUN) begin
         ws_d    = sum;
         wc_d    = carry;
         q_d     = qpos ? {q_q[6:0], 1'b1} : qneg ? {qm_q[6:0], 1'b1} : {q_q[6:0], 1'b0};
         qm_d    = qpos ? {q_q[6:0], 1'b0} : qneg ? {qm_q[6:0], 1'b0} : {qm_q[6:0], 1'b1};
         count_d = count_q + 3'd1;
         state_d = count_q == 3'd7 ? FIX : RUN;
      end else if (state_q == FIX) begin
         state_d = DONE;
         busy_d  = 1'b0;
         done_d  = 1'b1;
         quot_d  = w_neg ? qm_q : q_q;
         rem_d   = rem_fix;
      end else if (state_q == ERR) begin
         state_d = DONE;
         done_d  = 1'b1;
         err_d   = 1'b1;
         quot_d  = '0;
         rem_d   = '0;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ws_q    <= '0;
         wc_q    <= '0;
         q_q     <= '0;
         qm_q    <= '0;
         d_q     <= '0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         ws_q    <= ws_d;
         wc_q    <= wc_d;
         q_q     <= q_d;
         qm_q    <= qm_d;
         d_q     <= d_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
      end
   end
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.err  = err_q;
   assign bus.quot = quot_q;
   assign bus.rem  = rem_q;
endmodule

module csa11 (
   input  logic [10:0] mdivi,
   input  logic [10:0] SumN2,
   input  logic [10:0] CarryN2,
   output logic [10:0] Sum,
   output logic [10:0] Carry
);
   assign Sum   = mdivi ^ SumN2 ^ CarryN2;
   assign Carry = {(mdivi[9:0] & SumN2[9:0]) | (mdivi[9:0] & CarryN2[9:0]) | (SumN2[9:0] & CarryN2[9:0]), 1'b0};
endmodule

// File: tb/tb_srt2_div8.sv
// tb_srt2_div8: directed and random-sweep bench for srt2_div8 against a transaction-level integer model.
module tb_srt2_div8;
   logic clk = 1'b0;
   logic reset = 1'b1;
   srt2_div8_if bus ();
   srt2_div8 dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
`ifdef SRT_DIV_REM_EN
   localparam bit REM_EN = 1'b1;
`else
   localparam bit REM_EN = 1'b0;
`endif
   int compared = 0;
   int mismatched = 0;
   int qm_hits = 0;
   int left = 0;
   logic m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, perr = 1'b0;
   logic [7:0] m_quot = 8'h00, m_rem = 8'h00, pq = 8'h00, pr = 8'h00;
   function automatic logic bad_ops(input logic [7:0] x, input logic [7:0] d);
      return d < 8'h80 || x >= d;
   endfunction
   function automatic logic [7:0] ref_quot(input logic [7:0] x, input logic [7:0] d);
      return bad_ops(x, d) ? 8'h00 : 8'((int'(x) * 256) / int'(d));
   endfunction
   function automatic logic [7:0] ref_rem(input logic [7:0] x, input logic [7:0] d);
      return (bad_ops(x, d) || !REM_EN) ? 8'h00 : 8'((int'(x) * 256) % int'(d));
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   // Model: an accepted request yields its result 9 edges later (1 for bad operands).
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         left <= 0;
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_err <= 1'b0;
         m_quot <= 8'h00;
         m_rem <= 8'h00;
      end else if (left > 0) begin
         left <= left - 1;
         m_done <= (left == 1);
         if (left == 1) begin
            m_busy <= 1'b0;
            m_err <= perr;
            m_quot <= pq;
            m_rem <= pr;
         end
      end else begin
         m_done <= 1'b0;
         if (bus.start) begin
            perr <= bad_ops(bus.dividend, bus.divisor);
            pq <= ref_quot(bus.dividend, bus.divisor);
            pr <= ref_rem(bus.dividend, bus.divisor);
            left <= bad_ops(bus.dividend, bus.divisor) ? 1 : 9;
            m_busy <= !bad_ops(bus.dividend, bus.divisor);
         end
      end
   end
   always @(negedge clk) begin
      if (!reset) begin
         chk("busy", bus.busy, m_busy);
         chk("done", bus.done, m_done);
         if (m_done) begin
            chk("err", bus.err, m_err);
            chk("quot", bus.quot, m_quot);
            chk("rem", bus.rem, m_rem);
         end
         if (dut.state_q == 3'd2 && dut.w_neg) qm_hits <= qm_hits + 1;
      end
   end
   task automatic op(input logic [7:0] x, input logic [7:0] d, input logic [7:0] eq, input logic [7:0] er,
                     input logic ee, input int lat, input int poke);
      int n;
      bus.start = 1'b1;
      bus.dividend = x;
      bus.divisor = d;
      @(negedge clk);
      bus.start = 1'b0;
      n = 1;
      while (!bus.done && n < 40) begin
         if (n == poke) begin
            bus.start = 1'b1;
            bus.dividend = 8'h10;
            bus.divisor = 8'h90;
         end
         @(negedge clk);
         bus.start = 1'b0;
         n++;
      end
      chk("lit_latency", n, lat);
      chk("lit_err", bus.err, ee);
      chk("lit_quot", bus.quot, eq);
      chk("lit_rem", bus.rem, REM_EN ? er : 8'h00);
   endtask
   initial begin
      int n;
      logic [7:0] d8;
      bus.start = 1'b0;
      bus.dividend = 8'h00;
      bus.divisor = 8'h80;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_quot", bus.quot, 0);
      chk("rst_rem", bus.rem, 0);
      chk("rst_state", dut.state_q, 0);
      op(8'h40, 8'h80, 8'h80, 8'h00, 1'b0, 10, 0);
      op(8'h7F, 8'hC0, 8'hA9, 8'h40, 1'b0, 10, 0);
      op(8'hFE, 8'hFF, 8'hFE, 8'hFE, 1'b0, 10, 0);
      op(8'h10, 8'h40, 8'h00, 8'h00, 1'b1, 2, 0);
      op(8'h90, 8'h80, 8'h00, 8'h00, 1'b1, 2, 0);
      op(8'h80, 8'h80, 8'h00, 8'h00, 1'b1, 2, 0);
      op(8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 10, 0);
      bus.start = 1'b1;
      bus.dividend = 8'h7F;
      bus.divisor = 8'hC0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_quot", bus.quot, 0);
      chk("abort_rem", bus.rem, 0);
      chk("abort_state", dut.state_q, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      op(8'h01, 8'hFF, 8'h01, 8'h01, 1'b0, 10, 0);
      op(8'hFE, 8'hFF, 8'hFE, 8'hFE, 1'b0, 10, 4);
      bus.start = 1'b1;
      bus.dividend = 8'h7F;
      bus.divisor = 8'hC0;
      @(negedge clk);
      bus.dividend = 8'h40;
      bus.divisor = 8'h80;
      n = 1;
      while (!bus.done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_lat1", n, 10);
      chk("b2b_quot1", bus.quot, 8'hA9);
      @(negedge clk);
      bus.start = 1'b0;
      n = 1;
      while (!bus.done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_lat2", n, 10);
      chk("b2b_quot2", bus.quot, 8'h80);
      chk("b2b_rem2", bus.rem, 8'h00);
      d8 = 8'($urandom_range(128, 255));
      bus.divisor = d8;
      bus.dividend = 8'($urandom_range(0, int'(d8) - 1));
      bus.start = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!bus.done && n < 40);
         chk("sweep_latency", n, 10);
         d8 = 8'($urandom_range(128, 255));
         bus.divisor = d8;
         bus.dividend = 8'($urandom_range(0, int'(d8) - 1));
      end
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("qm_path_seen", qm_hits > 0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
